// File: rtl/stereo_frame_sched.sv
// Interleaves left/right sample streams into one output FIFO as L,R frames.
// Pair-atomic frame start plus a watchdog that zero-fills a missing right sample.
module stereo_frame_sched #(
  parameter int DATA_SIZE      = 32,
  parameter int COUNT_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PAIR_ATOMIC    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear_err,
  input  logic [DATA_SIZE-1:0]   left_in_dout,
  input  logic                   left_in_empty,
  output logic                   left_in_rd_en,
  input  logic [DATA_SIZE-1:0]   right_in_dout,
  input  logic                   right_in_empty,
  output logic                   right_in_rd_en,
  output logic [DATA_SIZE-1:0]   out_din,
  output logic                   out_wr_en,
  input  logic                   out_full,
  output logic                   out_chan,
  output logic [COUNT_WIDTH-1:0] pair_count,
  output logic                   skew_err,
  output logic                   busy
);

  // wd counts right-empty stall cycles; reaching WD_FIRED means the watchdog has
  // fired and a zero sample goes out on the next cycle the output has room.
  localparam logic [15:0] WD_FIRED = 16'(TIMEOUT_CYCLES);

  typedef enum logic {S_L, S_R} state_t;

  state_t                 state_reg, state_next;
  logic [COUNT_WIDTH-1:0] pair_count_reg, pair_count_next;
  logic                   skew_err_reg, skew_err_next;
  logic [15:0]            wd_reg, wd_next;
  logic                   go_l, go_r, sub;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= S_L;
      pair_count_reg <= '0;
      skew_err_reg   <= 1'b0;
      wd_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      pair_count_reg <= pair_count_next;
      skew_err_reg   <= skew_err_next;
      wd_reg         <= wd_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pair_count_next = pair_count_reg;
    skew_err_next   = skew_err_reg & ~clear_err;
    wd_next         = wd_reg;
    left_in_rd_en   = 1'b0;
    right_in_rd_en  = 1'b0;
    out_wr_en       = 1'b0;
    out_din         = '0;
    out_chan        = 1'b0;

    go_l = enable & ~left_in_empty & ~out_full & ((PAIR_ATOMIC == 0) | ~right_in_empty);
    go_r = ~right_in_empty & ~out_full;
    sub  = (wd_reg == WD_FIRED) & right_in_empty & ~out_full;

    case (state_reg)
      S_L: begin
        if (go_l) begin
          left_in_rd_en = 1'b1;
          out_wr_en     = 1'b1;
          out_din       = left_in_dout;
          state_next    = S_R;
        end
      end
      S_R: begin
        if (go_r) begin
          right_in_rd_en  = 1'b1;
          out_wr_en       = 1'b1;
          out_din         = right_in_dout;
          out_chan        = 1'b1;
          pair_count_next = pair_count_reg + 1'b1;
          wd_next         = '0;
          state_next      = S_L;
        end else if (sub) begin
          out_wr_en       = 1'b1;
          out_chan        = 1'b1;
          pair_count_next = pair_count_reg + 1'b1;
          skew_err_next   = 1'b1;
          wd_next         = '0;
          state_next      = S_L;
        end else if (right_in_empty && wd_reg != WD_FIRED) begin
          // Only a missing right sample advances the watchdog; out_full stalls hold it.
          wd_next = wd_reg + 16'd1;
        end
      end
      default: state_next = S_L;
    endcase

    if (reset) begin
      left_in_rd_en  = 1'b0;
      right_in_rd_en = 1'b0;
      out_wr_en      = 1'b0;
      out_din        = '0;
      out_chan       = 1'b0;
    end
  end

  assign pair_count = pair_count_reg;
  assign skew_err   = skew_err_reg;
  assign busy       = (state_reg == S_R);

endmodule
